// File: rtl/camera_frame_writer.sv
// OV7670 byte-stream capture: assembles RGB565 pixels, reformats, decimates and skips
// frames, and drives a framebuffer write port with frame status and sticky error flags.
module camera_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int OUT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [1:0]        decim,
  input  logic [3:0]        skip,
  input  logic              clr_err,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        p_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              frame_active,
  output logic [9:0]        line_cnt,
  output logic              err_short,
  output logic              err_ovf
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] LIM0 = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LIM1 = ADDR_W'((H_ACTIVE >> 1) * (V_ACTIVE >> 1) - 1);
  localparam logic [ADDR_W-1:0] LIM2 = ADDR_W'((H_ACTIVE >> 2) * (V_ACTIVE >> 2) - 1);

  typedef enum logic [1:0] {WAIT_VS, ARMED, ACTIVE, SKIP} state_t;

  state_t            state;
  logic              vs_r, vs_q, hr_r, hr_q;
  logic [7:0]        d_r, hi_byte;
  logic              phase;
  logic [XW-1:0]     x;
  logic [3:0]        skip_cnt, skip_l;
  logic [1:0]        mode_l, decim_l;
  logic              p1_vld;
  logic [15:0]       p1_pix;
  logic [ADDR_W-1:0] addr_nxt, limit;
  logic              at_lim;
  logic [1:0]        m;
  logic              keep, vs_fall, vs_rise, hr_fall;
  logic [7:0]        r8, g8, b8;
  logic [10:0]       ysum;
  logic [15:0]       fmt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_r <= 1'b0; vs_q <= 1'b0; hr_r <= 1'b0; hr_q <= 1'b0; d_r <= '0;
    end else begin
      vs_r <= vsync; vs_q <= vs_r; hr_r <= href; hr_q <= hr_r; d_r <= p_data;
    end
  end

  assign vs_fall = vs_q & ~vs_r;
  assign vs_rise = ~vs_q & vs_r;
  assign hr_fall = hr_q & ~hr_r;

  always_comb begin
    m = 2'd3;
    limit = LIM2;
    case (decim_l)
      2'd0:    begin m = 2'd0; limit = LIM0; end
      2'd1:    begin m = 2'd1; limit = LIM1; end
      default: begin m = 2'd3; limit = LIM2; end
    endcase
  end

  assign keep = ((x[1:0] & m) == 2'b00) && ((line_cnt[1:0] & m) == 2'b00);

  // Luma operands are widened to 8 bits by replicating their MSBs
  assign r8   = {p1_pix[15:11], p1_pix[15:13]};
  assign g8   = {p1_pix[10:5], p1_pix[10:9]};
  assign b8   = {p1_pix[4:0], p1_pix[4:2]};
  assign ysum = (11'(r8) << 1) + 11'(g8) * 11'd5 + 11'(b8);

  always_comb begin
    fmt = p1_pix;
    case (mode_l)
      2'd0: fmt = p1_pix;
      2'd1: fmt = {10'b0, p1_pix[10:5]};
      2'd2: fmt = {8'b0, ysum[10:3]};
      2'd3: fmt = {1'b0, p1_pix[15:11], p1_pix[10:6], p1_pix[4:0]};
      default: fmt = p1_pix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_VS;
      phase <= 1'b0; x <= '0; hi_byte <= '0;
      skip_cnt <= '0; skip_l <= '0; mode_l <= '0; decim_l <= '0;
      p1_vld <= 1'b0; p1_pix <= '0; addr_nxt <= '0; at_lim <= 1'b0;
      wr_addr <= '0; wr_data <= '0; wr_en <= 1'b0;
      frame_done <= 1'b0; frame_active <= 1'b0; line_cnt <= '0;
      err_short <= 1'b0; err_ovf <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      p1_vld     <= 1'b0;
      phase      <= hr_r ? ~phase : 1'b0;
      if (!hr_r)     x <= '0;
      else if (phase) x <= x + 1'b1;
      if (hr_r && !phase) hi_byte <= d_r;
      // Error events below are assigned later, so they win over a coincident clear
      if (clr_err) begin
        err_short <= 1'b0;
        err_ovf   <= 1'b0;
      end
      case (state)
        WAIT_VS: if (vs_r) state <= ARMED;
        ARMED: if (vs_fall) begin
          if (en && skip_cnt == 4'd0) begin
            state        <= ACTIVE;
            mode_l       <= mode;
            decim_l      <= decim;
            skip_l       <= skip;
            frame_active <= 1'b1;
            wr_addr      <= '0;
            addr_nxt     <= '0;
            at_lim       <= 1'b0;
            line_cnt     <= '0;
          end else begin
            state <= SKIP;
            if (skip_cnt != 4'd0) skip_cnt <= skip_cnt - 4'd1;
          end
        end
        SKIP: if (vs_rise) state <= ARMED;
        ACTIVE: begin
          if (hr_r && phase) begin
            p1_vld <= keep;
            p1_pix <= {hi_byte, d_r};
          end
          if (hr_fall) begin
            line_cnt <= line_cnt + 10'd1;
            if (x != XW'(H_ACTIVE) || phase) err_short <= 1'b1;
          end
          if (vs_rise) begin
            state        <= ARMED;
            frame_done   <= 1'b1;
            frame_active <= 1'b0;
            skip_cnt     <= skip_l;
          end
        end
        default: state <= WAIT_VS;
      endcase
      // Once the limit address has been written, the address holds and later pixels are dropped
      if (p1_vld) begin
        if (at_lim) err_ovf <= 1'b1;
        else begin
          wr_en   <= 1'b1;
          wr_data <= OUT_W'(fmt);
          wr_addr <= addr_nxt;
          if (addr_nxt == limit) at_lim <= 1'b1;
          else addr_nxt <= addr_nxt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer on a small 8x4 frame: stimulus pushes expected
// writes, a negedge monitor pops and compares every wr_en strobe.
module tb_camera_frame_writer;
  localparam int H = 8, V = 4, AW = 5, OW = 16;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr_err = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [1:0] mode = '0, decim = '0;
  logic [3:0] skip = '0;
  logic [7:0] p_data = '0;
  logic [AW-1:0] wr_addr;
  logic [OW-1:0] wr_data;
  logic wr_en, frame_done, frame_active, err_short, err_ovf;
  logic [9:0] line_cnt;

  camera_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .decim(decim), .skip(skip),
    .clr_err(clr_err), .vsync(vsync), .href(href), .p_data(p_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .frame_done(frame_done),
    .frame_active(frame_active), .line_cnt(line_cnt), .err_short(err_short), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] a; logic [OW-1:0] d;} wr_t;
  wr_t q[$];
  int n_chk = 0, n_fail = 0, fd_cnt = 0, exp_fd = 0, cyc = 0, lat_ref = 0;
  bit lat_arm = 0, cap = 0, e_lim = 0;
  int b_decim = 0;
  logic [AW-1:0] e_addr = '0;

  localparam logic [1:0]  F_MODE [5] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd2};
  localparam logic [15:0] F_PIX  [5] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'hF81F, 16'h07E0};
  localparam logic [15:0] F_EXP  [5] = '{16'h00FF, 16'h003F, 16'h003F, 16'h7C1F, 16'h009F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done) fd_cnt++;
        if (wr_en) begin
          if (lat_arm) begin
            chk("first_write_latency", 64'(cyc), 64'(lat_ref + 2));
            lat_arm = 0;
          end
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", wr_addr, wr_data);
          end else begin
            e = q.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e.a));
            chk("wr_data", 64'(wr_data), 64'(e.d));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    p_data = b;
    tick();
  endtask

  function automatic logic [AW-1:0] lim_of(input int d);
    return AW'((H >> d) * (V >> d) - 1);
  endfunction

  task automatic expect_px(input int ln, input int x, input logic [15:0] data);
    int m;
    m = (b_decim == 0) ? 0 : (b_decim == 1) ? 1 : 3;
    if (cap && ((x & m) == 0) && ((ln & m) == 0) && !e_lim) begin
      q.push_back({e_addr, data});
      if (e_addr == lim_of(b_decim)) e_lim = 1;
      else e_addr = e_addr + 1'b1;
    end
  endtask

  task automatic send_line(input int ln, input int npx, input bit odd, input bit cst,
                           input logic [15:0] cpix, input logic [15:0] cexp, input bit lat);
    logic [15:0] pix;
    logic [7:0] lb, xb;
    for (int x = 0; x < npx; x++) begin
      lb = 8'(ln);
      xb = 8'(x);
      pix = cst ? cpix : (16'hA53C ^ {lb, xb});
      expect_px(ln, x, cst ? cexp : pix);
      send_byte(pix[15:8]);
      if (lat && x == 0) begin
        lat_ref = cyc + 1;
        lat_arm = 1;
      end
      send_byte(pix[7:0]);
    end
    if (odd) send_byte(8'h77);
    href = 1'b0;
    p_data = '0;
    repeat (3) tick();
  endtask

  task automatic send_frame(input int nlines, input bit c, input bit cst, input logic [15:0] cpix,
                            input logic [15:0] cexp, input int short_ln, input int odd_ln, input bit lat);
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    cap = c;
    e_addr = '0;
    e_lim = 0;
    repeat (3) tick();
    chk("frame_active", 64'(frame_active), 64'(c));
    for (int ln = 0; ln < nlines; ln++)
      send_line(ln, (ln == short_ln) ? H - 1 : H, ln == odd_ln, cst, cpix, cexp, lat && ln == 0);
    vsync = 1'b1;
    repeat (4) tick();
    if (c) exp_fd++;
    chk("frame_done_count", 64'(fd_cnt), 64'(exp_fd));
    chk("frame_active_end", 64'(frame_active), 64'd0);
    if (c) chk("line_cnt", 64'(line_cnt), 64'(nlines));
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outputs", {wr_addr, wr_data, wr_en, frame_done, frame_active, line_cnt, err_short, err_ovf}, 64'd0);
    rst = 1'b0;
    en = 1'b1;
    tick();

    // Full-resolution RGB565 frame with first-write latency check
    b_decim = 0; decim = 2'd0; mode = 2'd0;
    send_frame(V, 1, 0, '0, '0, -1, -1, 1);
    chk("last_addr_d0", 64'(wr_addr), 64'(H * V - 1));
    chk("no_err_short", 64'(err_short), 64'd0);
    chk("no_err_ovf", 64'(err_ovf), 64'd0);

    // Decimation 1, 2, and 3 (treated as 2)
    b_decim = 1; decim = 2'd1;
    send_frame(V, 1, 0, '0, '0, -1, -1, 0);
    chk("last_addr_d1", 64'(wr_addr), 64'd7);
    b_decim = 2; decim = 2'd2;
    send_frame(V, 1, 0, '0, '0, -1, -1, 0);
    chk("last_addr_d2", 64'(wr_addr), 64'd1);
    decim = 2'd3;
    send_frame(V, 1, 0, '0, '0, -1, -1, 0);
    chk("last_addr_d3", 64'(wr_addr), 64'd1);

    // Output formats on constant-colour frames
    for (int i = 0; i < 5; i++) begin
      mode = F_MODE[i];
      send_frame(V, 1, 1, F_PIX[i], F_EXP[i], -1, -1, 0);
    end
    mode = 2'd0;

    // Skip 2: frames 1 and 4 of 6 captured
    skip = 4'd2;
    for (int f = 0; f < 6; f++) send_frame(V, (f == 0 || f == 3), 0, '0, '0, -1, -1, 0);
    skip = 4'd0;

    // Capture disabled at frame start
    en = 1'b0;
    send_frame(V, 0, 0, '0, '0, -1, -1, 0);
    en = 1'b1;

    // Short line, odd byte count, overflow, clear
    b_decim = 0; decim = 2'd0;
    send_frame(V, 1, 0, '0, '0, 1, -1, 0);
    chk("err_short_short_line", 64'(err_short), 64'd1);
    chk("err_ovf_short_line", 64'(err_ovf), 64'd0);
    pulse_clr();
    chk("err_short_cleared", 64'(err_short), 64'd0);
    send_frame(V, 1, 0, '0, '0, -1, 2, 0);
    chk("err_short_odd_byte", 64'(err_short), 64'd1);
    pulse_clr();
    send_frame(V + 2, 1, 0, '0, '0, -1, -1, 0);
    chk("err_ovf_set", 64'(err_ovf), 64'd1);
    chk("addr_held_at_limit", 64'(wr_addr), 64'(H * V - 1));
    chk("err_short_ovf_frame", 64'(err_short), 64'd0);
    pulse_clr();
    chk("flags_cleared", {err_short, err_ovf}, 64'd0);

    // Reset mid-line, release mid-frame
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    cap = 1; e_addr = '0; e_lim = 0;
    repeat (3) tick();
    expect_px(0, 0, 16'h1122);
    send_byte(8'h11); send_byte(8'h22);
    expect_px(0, 1, 16'h3344);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    rst = 1'b1;
    cap = 0;
    #1;
    chk("reset_mid_line", {wr_addr, wr_data, wr_en, frame_done, frame_active, line_cnt, err_short, err_ovf}, 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    send_byte(8'h88); send_byte(8'h99);
    href = 1'b0;
    repeat (3) tick();
    send_line(1, H, 0, 0, '0, '0, 0);
    send_line(2, H, 0, 0, '0, '0, 0);
    chk("no_capture_after_release", 64'(frame_active), 64'd0);
    send_frame(V, 1, 0, '0, '0, -1, -1, 0);
    chk("last_addr_after_reset", 64'(wr_addr), 64'(H * V - 1));

    repeat (4) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    chk("total_frame_done", 64'(fd_cnt), 64'd15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
